regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Multi-read, dual-write register file with an integrated
//               scoreboard (one busy bit per register). Register 0 is
//               hard-wired to zero and can never become busy.
//
// Optional feature macro: REGFILE_SB_BYPASS_EN
//   undefined : reads return the pre-write value in the cycle of a write,
//               and read_busy_o is the registered busy bit.
//   defined   : same-cycle write data is forwarded to matching read ports
//               (port 1 over port 0), and a register being written this
//               cycle reports not-busy unless it is also being issued.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        asynchronous active-high reset (clears data and busy)
//   read_reg_i     NREAD packed read addresses, port k at [k*AW +: AW]
//   read_data_o    NREAD packed read data,      port k at [k*XLEN +: XLEN]
//   read_busy_o    busy bit of each addressed register
//   write0_*       write port 0 (enable, address, data)
//   write1_*       write port 1 (enable, address, data), wins on collision
//   issue_i/_reg_i mark destination register pending at the next edge
//   stall_o        any read port busy, or WAW hit on the issue destination
//
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NREAD*AW-1:0]     read_reg_i,
    output logic [NREAD*XLEN-1:0]   read_data_o,
    output logic [NREAD-1:0]        read_busy_o,
    input  logic                    write0_i,
    input  logic [AW-1:0]           write0_reg_i,
    input  logic [XLEN-1:0]         write0_data_i,
    input  logic                    write1_i,
    input  logic [AW-1:0]           write1_reg_i,
    input  logic [XLEN-1:0]         write1_data_i,
    input  logic                    issue_i,
    input  logic [AW-1:0]           issue_reg_i,
    output logic                    stall_o
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic             w_wr0_en;
    logic             w_wr1_en;
    logic             w_iss_en;
    logic [NREGS-1:0] w_busy_next;
    logic             w_waw;

    // Writes and issues to register 0 are dropped here, so nothing below
    // ever has to special-case them.
    assign w_wr0_en = write0_i && (write0_reg_i != '0);
    assign w_wr1_en = write1_i && (write1_reg_i != '0);
    assign w_iss_en = issue_i  && (issue_reg_i  != '0);

    // Data storage. Port 1 is applied after port 0 so it wins a collision.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr0_en) begin
                r_regs[write0_reg_i] <= write0_data_i;
            end
            if (w_wr1_en) begin
                r_regs[write1_reg_i] <= write1_data_i;
            end
        end
    end

    // Writes clear busy first, then an issue sets it, so an issue to the
    // register being written leaves it busy.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr0_en) begin
            w_busy_next[write0_reg_i] = 1'b0;
        end
        if (w_wr1_en) begin
            w_busy_next[write1_reg_i] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_next[issue_reg_i] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    generate
        for (genvar k = 0; k < NREAD; k++) begin : g_read
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_busy;

            assign w_addr = read_reg_i[k*AW +: AW];

            always_comb begin
                w_data = (w_addr == '0) ? '0 : r_regs[w_addr];
                w_busy = r_busy[w_addr];
`ifdef REGFILE_SB_BYPASS_EN
                // Forwarding is suppressed during reset so that the outputs
                // stay at zero while reset_i is held.
                if (!reset_i && (w_addr != '0)) begin
                    if (w_wr1_en && (write1_reg_i == w_addr)) begin
                        w_data = write1_data_i;
                    end else if (w_wr0_en && (write0_reg_i == w_addr)) begin
                        w_data = write0_data_i;
                    end
                    if (((w_wr1_en && (write1_reg_i == w_addr)) ||
                         (w_wr0_en && (write0_reg_i == w_addr))) &&
                        !(w_iss_en && (issue_reg_i == w_addr))) begin
                        w_busy = 1'b0;
                    end
                end
`endif
            end

            assign read_data_o[k*XLEN +: XLEN] = w_data;
            assign read_busy_o[k]              = w_busy;
        end
    endgenerate

    // WAW hazard: issuing to a register that already has a write in flight.
    assign w_waw   = issue_i && r_busy[issue_reg_i];
    assign stall_o = (|read_busy_o) || w_waw;

endmodule
`default_nettype wire
